// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path: mode encodings, bar colours,
// default active-area size and small combinational helpers.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  // One axis of the bouncing box: position plus travel direction (rev=1 means left/up).
  typedef struct packed {
    logic [15:0] pos;
    logic        rev;
  } axis_t;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction

  // x / bar_w without a divider; anything past the last bar saturates at 7.
  function automatic logic [2:0] bar_index(input logic [15:0] x, input int bar_w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++)
      if (32'(x) >= 32'(i * bar_w)) idx = 3'(i);
    return idx;
  endfunction

  // Bounce rule, evaluated unsigned at 17 bits so the sums cannot wrap.
  function automatic axis_t axis_step(input axis_t a, input int step,
                                      input int size, input int limit);
    logic [16:0] pos;
    logic [16:0] stp;
    axis_t       n;
    pos = {1'b0, a.pos};
    stp = 17'(step);
    n   = a;
    if (!a.rev) begin
      if (pos + stp + 17'(size) > 17'(limit)) begin
        n.rev = 1'b1;
        n.pos = 16'(pos - stp);
      end else begin
        n.pos = 16'(pos + stp);
      end
    end else if (pos < stp) begin
      n.rev = 1'b0;
      n.pos = 16'(pos + stp);
    end else begin
      n.pos = 16'(pos - stp);
    end
    return n;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker; advances one step per axis on every frame-start pulse.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic        i_frame_st,
  output logic [15:0] box_x,
  output logic [15:0] box_y
);

  axis_t ax_q;
  axis_t ay_q;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      ax_q <= '{pos: 16'd0, rev: 1'b0};
      ay_q <= '{pos: 16'd0, rev: 1'b0};
    end else if (i_frame_st) begin
      ax_q <= axis_step(ax_q, BOX_STEP, BOX_SIZE, H_ACTIVE);
      ay_q <= axis_step(ay_q, BOX_STEP, BOX_SIZE, V_ACTIVE);
    end
  end

  assign box_x = ax_q.pos;
  assign box_y = ay_q.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source behind the VGA timing generator; two-stage pipeline
// keeps syncs, data-enable and RGB aligned at a fixed two-cycle latency.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE  = VGA_H_ACTIVE,
  parameter int          V_ACTIVE  = VGA_V_ACTIVE,
  parameter int          BAR_W     = 80,
  parameter int          CHK_SHIFT = 5,
  parameter int          BOX_SIZE  = 32,
  parameter int          BOX_STEP  = 2,
  parameter logic [23:0] BOX_COLOR = 24'hFF8000,
  parameter logic [23:0] BG_COLOR  = 24'h000040
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_active,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_frame_st,
  input  logic [1:0]  i_mode,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic [7:0]  o_frame_cnt
);

  localparam logic [16:0] SIZE17 = 17'(BOX_SIZE);

  mode_e       mode_q;
  logic [15:0] box_x;
  logic [15:0] box_y;

  logic        s1_active;
  logic        s1_hs;
  logic        s1_vs;
  logic [2:0]  s1_bar;
  logic        s1_chk;
  logic        s1_in_box;
  logic [7:0]  s1_grad_r;
  logic [7:0]  s1_grad_g;

  logic [16:0] x17;
  logic [16:0] y17;
  logic [16:0] bx17;
  logic [16:0] by17;
  logic        in_box_c;
  logic [23:0] pix_c;

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box (
    .i_pix_clk  (i_pix_clk),
    .i_rst      (i_rst),
    .i_frame_st (i_frame_st),
    .box_x      (box_x),
    .box_y      (box_y)
  );

  // Mode and frame counter only move in vertical blanking, so the visible frame never tears.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      mode_q      <= MODE_BARS;
      o_frame_cnt <= 8'd0;
    end else if (i_frame_st) begin
      mode_q      <= mode_e'(i_mode);
      o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end

  assign x17  = {1'b0, i_x};
  assign y17  = {1'b0, i_y};
  assign bx17 = {1'b0, box_x};
  assign by17 = {1'b0, box_y};
  assign in_box_c = (x17 >= bx17) && (x17 < bx17 + SIZE17) &&
                    (y17 >= by17) && (y17 < by17 + SIZE17);

  // Stage 1: register timing, reduce coordinates to per-pattern region flags.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      s1_active <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_bar    <= 3'd0;
      s1_chk    <= 1'b0;
      s1_in_box <= 1'b0;
      s1_grad_r <= 8'd0;
      s1_grad_g <= 8'd0;
    end else begin
      s1_active <= i_active;
      s1_hs     <= i_hs;
      s1_vs     <= i_vs;
      s1_bar    <= bar_index(i_x, BAR_W);
      s1_chk    <= i_x[CHK_SHIFT] ^ i_y[CHK_SHIFT];
      s1_in_box <= in_box_c;
      s1_grad_r <= i_x[9:2];
      s1_grad_g <= i_y[8:1];
    end
  end

  always_comb begin
    pix_c = 24'h000000;
    case (mode_q)
      MODE_BARS:  pix_c = bar_color(s1_bar);
      MODE_CHECK: pix_c = s1_chk ? 24'h000000 : 24'hFFFFFF;
      MODE_GRAD:  pix_c = {s1_grad_r, s1_grad_g, 8'h80};
      MODE_BOX:   pix_c = s1_in_box ? BOX_COLOR : BG_COLOR;
      default:    pix_c = 24'h000000;
    endcase
  end

  // Stage 2: final colour, blanked outside the active area.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_hs              <= 1'b1;
      o_vs              <= 1'b1;
      o_de              <= 1'b0;
      {o_r, o_g, o_b}   <= 24'h000000;
    end else begin
      o_hs              <= s1_hs;
      o_vs              <= s1_vs;
      o_de              <= s1_active;
      {o_r, o_g, o_b}   <= s1_active ? pix_c : 24'h000000;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: pixel expectations queued at drive time
// and compared when they emerge two cycles later.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic        i_active;
  logic        i_hs;
  logic        i_vs;
  logic        i_frame_st;
  logic [1:0]  i_mode;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic [7:0]  o_r;
  logic [7:0]  o_g;
  logic [7:0]  o_b;
  logic [7:0]  o_frame_cnt;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int nframes = 0;

  typedef struct {
    int          due;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    string       tag;
  } exp_t;

  exp_t sb[$];

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_pattern_gen dut (
    .i_pix_clk   (clk),
    .i_rst       (rst),
    .i_x         (i_x),
    .i_y         (i_y),
    .i_active    (i_active),
    .i_hs        (i_hs),
    .i_vs        (i_vs),
    .i_frame_st  (i_frame_st),
    .i_mode      (i_mode),
    .o_hs        (o_hs),
    .o_vs        (o_vs),
    .o_de        (o_de),
    .o_r         (o_r),
    .o_g         (o_g),
    .o_b         (o_b),
    .o_frame_cnt (o_frame_cnt)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert ({o_hs, o_vs, o_de, o_r, o_g, o_b} === {e.hs, e.vs, e.de, e.rgb}) else begin
        errors++;
        $error("FAIL %s: got hs/vs/de=%b%b%b rgb=%h, expected hs/vs/de=%b%b%b rgb=%h",
               e.tag, o_hs, o_vs, o_de, {o_r, o_g, o_b}, e.hs, e.vs, e.de, e.rgb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic act, input logic hs,
                       input logic vs, input logic fst, input logic [23:0] rgb,
                       input string tag, input bit chk);
    exp_t e;
    i_x        = 16'(x);
    i_y        = 16'(y);
    i_active   = act;
    i_hs       = hs;
    i_vs       = vs;
    i_frame_st = fst;
    if (chk) begin
      e.due = cyc + 2;
      e.hs  = hs;
      e.vs  = vs;
      e.de  = act;
      e.rgb = act ? rgb : 24'h000000;
      e.tag = tag;
      sb.push_back(e);
    end
    tick();
  endtask

  // Frame-start pulse in vertical blanking followed by one quiet blanking cycle.
  task automatic frame(input logic [1:0] m);
    i_mode = m;
    drive(0, 481, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, "frame_st", 1'b1);
    drive(0, 481, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, "frame_gap", 1'b1);
    nframes++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    i_mode     = 2'd0;
    i_x        = 16'd10;
    i_y        = 16'd10;
    i_active   = 1'b1;
    i_hs       = 1'b0;
    i_vs       = 1'b0;
    i_frame_st = 1'b1;
    tick();
    tick();
    tick();
    check("rst_hs", 32'(o_hs), 32'd1);
    check("rst_vs", 32'(o_vs), 32'd1);
    check("rst_de", 32'(o_de), 32'd0);
    check("rst_rgb", 32'({o_r, o_g, o_b}), 32'h0);
    check("rst_cnt", 32'(o_frame_cnt), 32'd0);

    rst = 1'b0;
    drive(700, 10, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, "idle", 1'b1);
    for (int b = 0; b < 8; b++) begin
      drive(b * 80,      10, 1'b1, 1'b1, 1'b1, 1'b0, bar_tab[b], "bar_lo", 1'b1);
      drive(b * 80 + 79, 10, 1'b1, 1'b1, 1'b1, 1'b0, bar_tab[b], "bar_hi", 1'b1);
    end
    drive(639, 10, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, "bar_x639", 1'b1);
    drive(656, 10, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, "hs_fall", 1'b1);
    drive(700, 10, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, "hs_low", 1'b1);
    drive(752, 10, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, "hs_rise", 1'b1);
    drive(80,  11, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFF00, "bar_x80", 1'b1);

    frame(2'd1);
    drive(31,  0,  1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF, "chk_31_0", 1'b1);
    drive(32,  0,  1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, "chk_32_0", 1'b1);
    drive(32,  32, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF, "chk_32_32", 1'b1);
    drive(0,   32, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, "chk_0_32", 1'b1);
    drive(700, 0,  1'b0, 1'b1, 1'b1, 1'b0, 24'h0, "chk_blank", 1'b1);

    frame(2'd2);
    drive(639, 479, 1'b1, 1'b1, 1'b1, 1'b0, 24'h9FEF80, "grad_639_479", 1'b1);
    drive(0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 24'h000080, "grad_0_0", 1'b1);

    while (nframes < 224) frame(2'd2);
    check("box_y_224", 32'(dut.box_y), 32'd448);
    check("box_x_224", 32'(dut.box_x), 32'd448);
    check("cnt_224", 32'(o_frame_cnt), 32'd224);
    frame(2'd2);
    check("box_y_225", 32'(dut.box_y), 32'd446);
    check("box_x_225", 32'(dut.box_x), 32'd450);
    while (nframes < 256) frame(2'd2);
    check("cnt_wrap", 32'(o_frame_cnt), 32'd0);
    while (nframes < 304) frame(2'd2);
    check("box_x_304", 32'(dut.box_x), 32'd608);
    frame(2'd2);
    check("box_x_305", 32'(dut.box_x), 32'd606);
    check("cnt_305", 32'(o_frame_cnt), 32'd49);

    frame(2'd0);
    i_mode = 2'd3;
    drive(0,   10, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF, "latch_hold_0", 1'b1);
    drive(300, 10, 1'b1, 1'b1, 1'b1, 1'b0, 24'h00FF00, "latch_hold_300", 1'b1);
    // 307th pulse: x has come back 608->602, y has climbed 448-2*83 = 282.
    frame(2'd3);
    drive(602, 282, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFF8000, "box_origin", 1'b1);
    drive(633, 313, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFF8000, "box_corner", 1'b1);
    drive(634, 282, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000040, "box_right", 1'b1);
    drive(601, 282, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000040, "box_left", 1'b1);
    drive(602, 314, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000040, "box_below", 1'b1);
    drive(700, 300, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, "drain", 1'b0);
    drive(700, 300, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, "drain", 1'b0);

    rst = 1'b1;
    drive(100, 100, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, "in_rst", 1'b0);
    drive(101, 100, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, "in_rst", 1'b0);
    check("midrst_hs", 32'(o_hs), 32'd1);
    check("midrst_de", 32'(o_de), 32'd0);
    check("midrst_rgb", 32'({o_r, o_g, o_b}), 32'h0);
    check("midrst_cnt", 32'(o_frame_cnt), 32'd0);
    check("midrst_box_x", 32'(dut.box_x), 32'd0);
    check("midrst_box_y", 32'(dut.box_y), 32'd0);
    rst = 1'b0;
    drive(0,   5, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF, "post_rst_bar0", 1'b1);
    drive(400, 5, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFF0000, "post_rst_bar5", 1'b1);
    for (int i = 0; i < 3; i++)
      drive(700, 5, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, "tail", 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
